// File: rtl/qu_common.sv
// Shared types and lane helpers for the Qu data-memory path.
package qu_common;

  localparam int ROB_AW = 6;

  typedef logic [ROB_AW-1:0] rob_addr_t;

  typedef enum logic [1:0] {
    DMEM_SIZE_BYTE   = 2'b00,
    DMEM_SIZE_HALF   = 2'b01,
    DMEM_SIZE_WORD   = 2'b10,
    DMEM_SIZE_WORD_X = 2'b11
  } dmem_size_t;

  typedef struct packed {
    logic       is_store;
    logic [31:0] addr;
    logic [31:0] data;
    dmem_size_t size;
    logic       is_unsigned;
    rob_addr_t  rob_addr;
    logic       kill;
  } dmem_req_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } dmem_state_t;

  function automatic logic is_misaligned(input dmem_size_t size, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (size)
      DMEM_SIZE_BYTE: r = 1'b0;
      DMEM_SIZE_HALF: r = off[0];
      default:        r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input dmem_size_t size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b1111;
    case (size)
      DMEM_SIZE_BYTE: m = 4'b0001;
      DMEM_SIZE_HALF: m = 4'b0011;
      default:        m = 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] lane_wdata(input dmem_size_t size, input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (size)
      DMEM_SIZE_BYTE: w = {4{data[7:0]}};
      DMEM_SIZE_HALF: w = {2{data[15:0]}};
      default:        w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                              input dmem_size_t size, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rdata >> {off, 3'b000};
    r  = sh;
    case (size)
      DMEM_SIZE_BYTE: r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      DMEM_SIZE_HALF: r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:        r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_unit_fifo.sv
// Request queue for dmem_unit; i_kill_loads marks every held load as killed
// while an entry written on the same edge keeps its clear kill bit.
module dmem_req_fifo
  import qu_common::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  dmem_req_t i_req,
  input  logic      i_pop,
  input  logic      i_kill_loads,
  output dmem_req_t o_head,
  output logic      o_empty,
  output logic      o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  dmem_req_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Stale slots may also get kill set; a later push overwrites them.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_loads && !r_mem[i].is_store) begin
          r_mem[i].kill <= 1'b1;
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_req;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory access unit: queues retire-stage loads/stores, drives a
// single-port synchronous SRAM with byte lanes, returns tagged load data.
module dmem_unit
  import qu_common::*;
#(
  parameter int DEPTH   = 4,
  parameter int SRAM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dmem_wr_en_in,
  input  logic               dmem_rd_en_in,
  input  logic [31:0]        dmem_addr_in,
  input  logic [31:0]        dmem_data_in,
  input  logic [1:0]         dmem_size_in,
  input  logic               dmem_unsigned_in,
  input  rob_addr_t          dmem_rob_addr_in,
  output logic               dmem_ready_out,
  input  logic               flush_in,
  output logic               ld_valid_out,
  output rob_addr_t          ld_rob_addr_out,
  output logic [31:0]        ld_data_out,
  output logic               ld_err_out,
  output logic               st_err_out,
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  dmem_state_t r_state;
  dmem_state_t w_next_state;
  dmem_req_t   w_req;
  dmem_req_t   w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_kill;
  logic        w_mis;
  logic        w_access;
  logic        w_unused;

  logic        r_ld_valid;
  rob_addr_t   r_ld_rob;
  logic [31:0] r_ld_data;
  logic        r_ld_err;
  logic        r_st_err;
  logic [1:0]  r_rd_off;
  dmem_size_t  r_rd_size;
  logic        r_rd_uns;
  rob_addr_t   r_rd_rob;

  assign w_push   = dmem_wr_en_in | dmem_rd_en_in;
  assign w_pop    = (r_state == ST_IDLE) & ~w_empty;
  assign w_unused = ^w_head.addr[31:SRAM_AW+2];

  // Incoming request; a store wins when both enables are high
  always_comb begin
    w_req             = '0;
    w_req.is_store    = dmem_wr_en_in;
    w_req.addr        = dmem_addr_in;
    w_req.data        = dmem_data_in;
    w_req.size        = dmem_size_t'(dmem_size_in);
    w_req.is_unsigned = dmem_unsigned_in;
    w_req.rob_addr    = dmem_rob_addr_in;
    w_req.kill        = 1'b0;
  end

  dmem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_req        (w_req),
    .i_pop        (w_pop),
    .i_kill_loads (flush_in),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full)
  );

  assign dmem_ready_out = ~w_full;

  // FSM next state and SRAM drive from the queue head
  always_comb begin
    w_next_state = r_state;
    w_access     = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 4'b0000;
    sram_addr    = '0;
    sram_wdata   = 32'h0000_0000;
    // A head load popped on a flush edge was queued before it, so it dies too.
    w_kill       = w_head.kill | (flush_in & ~w_head.is_store);
    w_mis        = is_misaligned(w_head.size, w_head.addr[1:0]);
    case (r_state)
      ST_IDLE: begin
        if (w_pop && !w_kill && !w_mis) begin
          w_access  = 1'b1;
          sram_en   = 1'b1;
          sram_addr = w_head.addr[SRAM_AW+1:2];
          if (w_head.is_store) begin
            sram_we      = lane_mask(w_head.size, w_head.addr[1:0]);
            sram_wdata   = lane_wdata(w_head.size, w_head.data);
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_RD_WAIT;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD_WAIT: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered load responses, error pulses and in-flight load context
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_valid <= 1'b0;
      r_ld_rob   <= '0;
      r_ld_data  <= 32'h0000_0000;
      r_ld_err   <= 1'b0;
      r_st_err   <= 1'b0;
      r_rd_off   <= 2'b00;
      r_rd_size  <= DMEM_SIZE_BYTE;
      r_rd_uns   <= 1'b0;
      r_rd_rob   <= '0;
    end else begin
      r_ld_valid <= 1'b0;
      r_ld_err   <= 1'b0;
      r_st_err   <= 1'b0;
      if (r_state == ST_RD_WAIT) begin
        if (!flush_in) begin
          r_ld_valid <= 1'b1;
          r_ld_rob   <= r_rd_rob;
          r_ld_data  <= load_extend(sram_rdata, r_rd_off, r_rd_size, r_rd_uns);
        end
      end else if (w_pop && !w_kill && w_mis) begin
        if (w_head.is_store) begin
          r_st_err <= 1'b1;
        end else begin
          r_ld_valid <= 1'b1;
          r_ld_err   <= 1'b1;
          r_ld_rob   <= w_head.rob_addr;
          r_ld_data  <= 32'h0000_0000;
        end
      end
      if (w_access && !w_head.is_store) begin
        r_rd_off  <= w_head.addr[1:0];
        r_rd_size <= w_head.size;
        r_rd_uns  <= w_head.is_unsigned;
        r_rd_rob  <= w_head.rob_addr;
      end
    end
  end

  assign ld_valid_out    = r_ld_valid;
  assign ld_rob_addr_out = r_ld_rob;
  assign ld_data_out     = r_ld_data;
  assign ld_err_out      = r_ld_err;
  assign st_err_out      = r_st_err;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: byte-level reference memory, SRAM model,
// expected loads queued at issue and popped by an independent monitor.
module tb_dmem_unit;
  import qu_common::*;

  localparam int DEPTH   = 4;
  localparam int SRAM_AW = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               dmem_wr_en_in = 1'b0;
  logic               dmem_rd_en_in = 1'b0;
  logic [31:0]        dmem_addr_in = 32'h0;
  logic [31:0]        dmem_data_in = 32'h0;
  logic [1:0]         dmem_size_in = 2'b00;
  logic               dmem_unsigned_in = 1'b0;
  rob_addr_t          dmem_rob_addr_in = '0;
  logic               dmem_ready_out;
  logic               flush_in = 1'b0;
  logic               ld_valid_out;
  rob_addr_t          ld_rob_addr_out;
  logic [31:0]        ld_data_out;
  logic               ld_err_out;
  logic               st_err_out;
  logic               sram_en;
  logic [3:0]         sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;

  dmem_unit #(.DEPTH(DEPTH), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .dmem_wr_en_in(dmem_wr_en_in), .dmem_rd_en_in(dmem_rd_en_in),
    .dmem_addr_in(dmem_addr_in), .dmem_data_in(dmem_data_in),
    .dmem_size_in(dmem_size_in), .dmem_unsigned_in(dmem_unsigned_in),
    .dmem_rob_addr_in(dmem_rob_addr_in), .dmem_ready_out(dmem_ready_out),
    .flush_in(flush_in), .ld_valid_out(ld_valid_out),
    .ld_rob_addr_out(ld_rob_addr_out), .ld_data_out(ld_data_out),
    .ld_err_out(ld_err_out), .st_err_out(st_err_out),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM model
  bit [31:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
      if (sram_we == 4'b0000) sram_rdata <= sram_mem[sram_addr];
    end
  end

  typedef struct {
    int          rob;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     mon_e;
  bit [7:0] ref_mem [0:4095];
  int       n_checks = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       st_err_seen = 0;
  int       st_err_exp = 0;
  int       sram_en_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT returns a load
  always @(negedge clk) begin
    if (st_err_out) st_err_seen++;
    if (sram_en) sram_en_seen++;
    if (ld_valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ld_valid: got rob %0d data %h, expected no response",
                 ld_rob_addr_out, ld_data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ld_rob", 32'(ld_rob_addr_out), 32'(mon_e.rob));
        chk("ld_data", ld_data_out, mon_e.data);
        chk("ld_err", 32'(ld_err_out), 32'(mon_e.err));
        if (mon_e.cyc >= 0) chk("ld_latency", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // One request cycle; the reference model applies the access rules at issue
  task automatic req(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [1:0] size, input logic uns,
                     input int rob, input logic flush, input bit lat_chk, output logic rdy);
    int   nb;
    int   a;
    bit   mis;
    exp_t e;
    dmem_wr_en_in    = wr;
    dmem_rd_en_in    = rd;
    dmem_addr_in     = addr;
    dmem_data_in     = data;
    dmem_size_in     = size;
    dmem_unsigned_in = uns;
    dmem_rob_addr_in = rob_addr_t'(rob);
    flush_in         = flush;
    rdy              = dmem_ready_out;
    @(posedge clk);
    #1;
    if (flush) exp_q.delete();
    if ((wr || rd) && rdy) begin
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      a   = int'(addr[11:0]);
      mis = (nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0);
      if (wr) begin
        if (mis) st_err_exp++;
        else for (int k = 0; k < nb; k++) ref_mem[a + k] = data[8*k +: 8];
      end else begin
        e.rob  = rob;
        e.err  = mis;
        e.data = 32'h0;
        if (!mis) begin
          for (int k = 0; k < nb; k++) e.data[8*k +: 8] = ref_mem[a + k];
          if (!uns && nb == 1 && e.data[7])  e.data = e.data | 32'hFFFF_FF00;
          if (!uns && nb == 2 && e.data[15]) e.data = e.data | 32'hFFFF_0000;
        end
        e.cyc = lat_chk ? (cyc + (mis ? 1 : 2)) : -1;
        exp_q.push_back(e);
      end
    end
    dmem_wr_en_in = 1'b0;
    dmem_rd_en_in = 1'b0;
    flush_in      = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ld_valid"}, 32'(ld_valid_out), 32'h0);
    chk({tag, "_st_err"}, 32'(st_err_out), 32'h0);
    chk({tag, "_sram_en"}, 32'(sram_en), 32'h0);
    chk({tag, "_sram_we"}, 32'(sram_we), 32'h0);
    chk({tag, "_sram_addr"}, 32'(sram_addr), 32'h0);
    chk({tag, "_sram_wdata"}, sram_wdata, 32'h0);
    chk({tag, "_ready"}, 32'(dmem_ready_out), 32'h1);
  endtask

  logic rdy;
  logic rdy_burst [8];
  int   en_snap;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset");
    chk("reset_ld_err", 32'(ld_err_out), 32'h0);
    rst = 1'b1;
    tick(2);

    // Word store then word load, fixed latency
    req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0, 1'b0, rdy);
    chk("st_word_en", 32'(sram_en), 32'h1);
    chk("st_word_we", 32'(sram_we), 32'hF);
    chk("st_word_addr", 32'(sram_addr), 32'h4);
    chk("st_word_wdata", sram_wdata, 32'hDEADBEEF);
    tick(3);
    req(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 3, 1'b0, 1'b1, rdy);
    tick(5);

    // Byte store at lane 3, signed and unsigned byte loads
    req(1'b1, 1'b0, 32'h13, 32'h000000A5, 2'd0, 1'b0, 0, 1'b0, 1'b0, rdy);
    chk("st_byte_we", 32'(sram_we), 32'h8);
    chk("st_byte_wdata", sram_wdata, 32'hA5A5A5A5);
    tick(2);
    req(1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b0, 5, 1'b0, 1'b1, rdy);
    tick(4);
    req(1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b1, 6, 1'b0, 1'b1, rdy);
    tick(4);

    // Misaligned half load and word store: no SRAM access
    en_snap = sram_en_seen;
    req(1'b0, 1'b1, 32'h11, 32'h0, 2'd1, 1'b0, 7, 1'b0, 1'b1, rdy);
    tick(3);
    req(1'b1, 1'b0, 32'h2, 32'h12345678, 2'd2, 1'b0, 0, 1'b0, 1'b0, rdy);
    tick(1);
    chk("st_err_pulse", 32'(st_err_out), 32'h1);
    tick(3);
    chk("misaligned_no_sram", 32'(sram_en_seen - en_snap), 32'h0);

    // Back-to-back loads fill the queue; the push seen while full is dropped
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 1'b1, 32'(4 * i), 32'h0, 2'd2, 1'b0, 10 + i, 1'b0, 1'b0, rdy);
      rdy_burst[i] = rdy;
    end
    chk("burst_ready_before_7th", 32'(rdy_burst[6]), 32'h1);
    chk("burst_full_after_7th", 32'(rdy_burst[7]), 32'h0);
    chk("burst_ready_after_pop", 32'(dmem_ready_out), 32'h1);
    tick(20);

    // Flush while the first load is in RD_WAIT
    req(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 0, 1'b0, 1'b0, rdy);
    req(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 20, 1'b0, 1'b0, rdy);
    req(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 21, 1'b0, 1'b0, rdy);
    req(1'b0, 1'b1, 32'h22, 32'h0, 2'd1, 1'b1, 22, 1'b1, 1'b0, rdy);
    tick(10);
    req(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 23, 1'b0, 1'b1, rdy);
    tick(5);

    // Reset during RD_WAIT
    req(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0, 30, 1'b0, 1'b0, rdy);
    tick(1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk_quiet("midreset");
    #3;
    rst = 1'b1;
    tick(6);

    // Randomised traffic with occasional flushes and both-enable requests
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      req((kind < 4) || (kind == 9), (kind >= 4), 32'($urandom_range(0, 63)), $urandom(),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), i % 64,
          ($urandom_range(0, 19) == 0), 1'b0, rdy);
      if ($urandom_range(0, 3) == 0) tick(1);
    end
    tick(30);
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    chk("st_err_count", 32'(st_err_seen), 32'(st_err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
